// File: rtl/imem_sync.sv
// Purpose : registered instruction memory with stall/flush fetch port and a sequential boot-load port.
// Latency : 1 cycle from pc/fetch_en sample to instr; load writes land on the accepting edge.
// Backpr. : stall holds the fetch outputs, flush kills them; load port is never backpressured (busy reports LOAD).
// Optional: define IMEM_BOUND_CHECK_EN to register addr_fault on out-of-range fetches (else tied 0).
`timescale 1ns/1ps

module imem_sync #(
    parameter int          DEPTH    = 128,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              misalign,
    output logic              addr_fault,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              busy,
    output logic [ADDR_W:0]   load_count
);

    // Physical index width of the array; the upper idx bits only matter for the range test.
    localparam int            MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    // The write pointer and the word count advance in lockstep, so one register serves both.
    logic [ADDR_W:0]   wp;
    logic [ADDR_W:0]   wp_nxt;
    logic              wr_en;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic [31:0]       rd_word;

    assign idx        = pc[ADDR_W+1:2];
    assign in_range   = ({1'b0, idx} < DEPTH_W);
    // Only consumed when in_range, so the truncated index never selects a missing word.
    assign rd_word    = mem[idx[MEM_AW-1:0]];
    assign busy       = (state == LOAD);
    assign load_count = wp;

    // pc bits above the index field are deliberately ignored.
    generate
        if (ADDR_W + 2 <= 31) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^pc[31:ADDR_W+2];
        end
    endgenerate

    // Load sequencing: restart on load_start, accept words until last or the array is full.
    always_comb begin
        state_nxt = state;
        wp_nxt    = wp;
        wr_en     = 1'b0;
        case (state)
            RUN: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    wp_nxt    = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wp_nxt = '0;
                end else if (load_valid && (wp < DEPTH_W)) begin
                    wr_en  = 1'b1;
                    wp_nxt = wp + ONE_W;
                    if (load_last || (wp_nxt == DEPTH_W)) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // State and write pointer; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            wp    <= '0;
        end else begin
            state <= state_nxt;
            wp    <= wp_nxt;
        end
    end

    // Array write port; contents survive reset so a loaded program stays resident.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp[MEM_AW-1:0]] <= load_data;
        end
    end

    // Fetch output register: flush > (LOAD idles the port) > stall > fetch > idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
        end else if (flush) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
        end else if (state == LOAD) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
        end else if (stall) begin
            instr       <= instr;
            instr_valid <= instr_valid;
            misalign    <= misalign;
        end else if (fetch_en) begin
            instr       <= in_range ? rd_word : NOP_WORD;
            instr_valid <= 1'b1;
            misalign    <= (pc[1:0] != 2'b00);
        end else begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
        end
    end

`ifdef IMEM_BOUND_CHECK_EN
    logic fault_q;

    // Fault flag follows the presented word: set by an out-of-range fetch, cleared by flush or a good fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (flush) begin
            fault_q <= 1'b0;
        end else if ((state == RUN) && !stall && fetch_en) begin
            fault_q <= !in_range;
        end
    end

    assign addr_fault = fault_q;
`else
    assign addr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_imem_sync.sv
`timescale 1ns/1ps

module tb_imem_sync;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IMEM_BOUND_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // DEPTH=128 instance
    logic        fetch_en = 0, stall = 0, flush = 0;
    logic [31:0] pc = '0;
    logic [31:0] instr;
    logic        instr_valid, misalign, addr_fault, busy;
    logic        load_start = 0, load_valid = 0, load_last = 0;
    logic [31:0] load_data = '0;
    logic [10:0] load_count;

    // DEPTH=8 instance
    logic        fetch_en8 = 0, stall8 = 0, flush8 = 0;
    logic [31:0] pc8 = '0;
    logic [31:0] instr8;
    logic        instr_valid8, misalign8, addr_fault8, busy8;
    logic        load_start8 = 0, load_valid8 = 0, load_last8 = 0;
    logic [31:0] load_data8 = '0;
    logic [4:0]  load_count8;

    imem_sync #(.DEPTH(128), .ADDR_W(10), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush), .pc(pc),
        .instr(instr), .instr_valid(instr_valid), .misalign(misalign), .addr_fault(addr_fault),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .busy(busy), .load_count(load_count)
    );

    imem_sync #(.DEPTH(8), .ADDR_W(4), .NOP_WORD(NOP)) dut8 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en8), .stall(stall8), .flush(flush8), .pc(pc8),
        .instr(instr8), .instr_valid(instr_valid8), .misalign(misalign8), .addr_fault(addr_fault8),
        .load_start(load_start8), .load_valid(load_valid8), .load_data(load_data8),
        .load_last(load_last8), .busy(busy8), .load_count(load_count8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        vld;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t        sbq[$];
    exp_t        sbq8[$];
    exp_t        cur;
    logic [31:0] model  [128];
    logic [31:0] model8 [8];
    int          wp_m = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch-port cycle on the 128-word instance and queue the expected registered result.
    task automatic drive_fetch(input logic fe, input logic st, input logic fl,
                               input logic [31:0] p, input bit bz);
        exp_t        nx;
        logic [9:0]  ix;
        nx       = cur;
        fetch_en = fe;
        stall    = st;
        flush    = fl;
        pc       = p;
        ix       = p[11:2];
        if (fl) begin
            nx = '{instr: NOP, vld: 1'b0, mis: 1'b0, flt: 1'b0};
        end else if (bz) begin
            nx.instr = NOP;
            nx.vld   = 1'b0;
        end else if (st) begin
            nx = cur;
        end else if (fe) begin
            nx.vld = 1'b1;
            nx.mis = (p[1:0] != 2'b00);
            if (ix >= 10'd128) begin
                nx.instr = NOP;
                nx.flt   = BC;
            end else begin
                nx.instr = model[ix[6:0]];
                nx.flt   = 1'b0;
            end
        end else begin
            nx.instr = NOP;
            nx.vld   = 1'b0;
        end
        cur = nx;
        sbq.push_back(nx);
    endtask

    task automatic test_reset();
        logic [31:0] got  [9];
        logic [31:0] want [9];
        string       nm   [9];
        #2 rst = 1'b1;
        #2;
        got[0] = instr;              want[0] = NOP;  nm[0] = "rst_instr";
        got[1] = 32'(instr_valid);   want[1] = 0;    nm[1] = "rst_valid";
        got[2] = 32'(misalign);      want[2] = 0;    nm[2] = "rst_misalign";
        got[3] = 32'(addr_fault);    want[3] = 0;    nm[3] = "rst_fault";
        got[4] = 32'(busy);          want[4] = 0;    nm[4] = "rst_busy";
        got[5] = 32'(load_count);    want[5] = 0;    nm[5] = "rst_load_count";
        got[6] = 32'(busy8);         want[6] = 0;    nm[6] = "rst_busy8";
        got[7] = 32'(load_count8);   want[7] = 0;    nm[7] = "rst_load_count8";
        got[8] = instr8;             want[8] = NOP;  nm[8] = "rst_instr8";
        for (int i = 0; i < 9; i++) begin
            total_cnt++;
            if (got[i] !== want[i])
                $display("FAIL %s: got %h expected %h", nm[i], got[i], want[i]);
            else
                pass_cnt++;
        end
        #8 rst = 1'b0;
        cur = '{instr: NOP, vld: 1'b0, mis: 1'b0, flt: 1'b0};
        tick();
    endtask

    task automatic test_load();
        logic [31:0] words [4];
        int          busy_cnt;
        words[0] = 32'h2008_0005;
        words[1] = 32'h2009_0003;
        words[2] = 32'h0109_5020;
        words[3] = 32'hAC0A_0000;
        busy_cnt = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (c >= 1 && c <= 4) begin
                load_valid = 1'b1;
                load_data  = words[c-1];
                load_last  = (c == 4);
                model[c-1] = words[c-1];
            end else begin
                load_valid = 1'b0;
                load_last  = 1'b0;
            end
            tick();
        end
        total_cnt++;
        if (busy_cnt !== 5) $display("FAIL load_busy_cycles: got %0d expected 5", busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if (load_count !== 11'd4) $display("FAIL load_count: got %0d expected 4", load_count);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL load_busy_end: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_fetch();
        logic [31:0] pcs [3];
        exp_t        e;
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            drive_fetch(1'b1, 1'b0, 1'b0, pcs[i], 1'b0);
            tick();
            e = sbq.pop_front();
            total_cnt++;
            if ({instr, instr_valid, misalign, addr_fault} !== e)
                $display("FAIL fetch[%0d]: got instr=%h vld=%b mis=%b flt=%b expected instr=%h vld=%b mis=%b flt=%b",
                         i, instr, instr_valid, misalign, addr_fault, e.instr, e.vld, e.mis, e.flt);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_stall_flush();
        logic        fe [5];
        logic        st [5];
        logic        fl [5];
        logic [31:0] pv [5];
        exp_t        e;
        fe[0]=1; st[0]=0; fl[0]=0; pv[0]=32'h4;
        fe[1]=1; st[1]=1; fl[1]=0; pv[1]=32'h8;
        fe[2]=1; st[2]=1; fl[2]=0; pv[2]=32'h8;
        fe[3]=1; st[3]=1; fl[3]=1; pv[3]=32'h8;
        fe[4]=0; st[4]=0; fl[4]=0; pv[4]=32'h0;
        for (int i = 0; i < 5; i++) begin
            drive_fetch(fe[i], st[i], fl[i], pv[i], 1'b0);
            tick();
            e = sbq.pop_front();
            total_cnt++;
            if ({instr, instr_valid, misalign, addr_fault} !== e)
                $display("FAIL stall_flush[%0d]: got instr=%h vld=%b mis=%b flt=%b expected instr=%h vld=%b mis=%b flt=%b",
                         i, instr, instr_valid, misalign, addr_fault, e.instr, e.vld, e.mis, e.flt);
            else
                pass_cnt++;
        end
        // Spot value straight from the test plan, independent of the model.
        total_cnt++;
        if (instr !== NOP) $display("FAIL stall_flush_nop: got %h expected %h", instr, NOP);
        else pass_cnt++;
    endtask

    task automatic test_misalign_range();
        logic        fe [6];
        logic        st [6];
        logic        fl [6];
        logic [31:0] pv [6];
        exp_t        e;
        fe[0]=1; st[0]=0; fl[0]=0; pv[0]=32'h6;
        fe[1]=1; st[1]=0; fl[1]=0; pv[1]=32'h200;
        fe[2]=0; st[2]=1; fl[2]=0; pv[2]=32'h0;
        fe[3]=1; st[3]=0; fl[3]=0; pv[3]=32'h0;
        fe[4]=1; st[4]=0; fl[4]=0; pv[4]=32'h203;
        fe[5]=0; st[5]=0; fl[5]=1; pv[5]=32'h0;
        for (int i = 0; i < 6; i++) begin
            drive_fetch(fe[i], st[i], fl[i], pv[i], 1'b0);
            tick();
            e = sbq.pop_front();
            total_cnt++;
            if ({instr, instr_valid, misalign, addr_fault} !== e)
                $display("FAIL misalign_range[%0d]: got instr=%h vld=%b mis=%b flt=%b expected instr=%h vld=%b mis=%b flt=%b",
                         i, instr, instr_valid, misalign, addr_fault, e.instr, e.vld, e.mis, e.flt);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_fetch_during_load();
        logic        ls [7];
        logic        lv [7];
        logic        ll [7];
        logic [31:0] ld [7];
        logic        fe [7];
        logic [31:0] pv [7];
        logic        bz [7];
        logic        eb [7];
        logic [10:0] elc [7];
        exp_t        e;
        ls[0]=1; lv[0]=0; ll[0]=0; ld[0]=32'h0;         fe[0]=0; pv[0]=32'h0; bz[0]=0; eb[0]=1; elc[0]=0;
        ls[1]=0; lv[1]=1; ll[1]=0; ld[1]=32'hA000_0001; fe[1]=1; pv[1]=32'h0; bz[1]=1; eb[1]=1; elc[1]=1;
        ls[2]=0; lv[2]=1; ll[2]=0; ld[2]=32'hA000_0002; fe[2]=1; pv[2]=32'h4; bz[2]=1; eb[2]=1; elc[2]=2;
        ls[3]=1; lv[3]=0; ll[3]=0; ld[3]=32'h0;         fe[3]=1; pv[3]=32'h0; bz[3]=1; eb[3]=1; elc[3]=0;
        ls[4]=0; lv[4]=1; ll[4]=1; ld[4]=32'h2008_000A; fe[4]=1; pv[4]=32'h0; bz[4]=1; eb[4]=0; elc[4]=1;
        ls[5]=0; lv[5]=0; ll[5]=0; ld[5]=32'h0;         fe[5]=1; pv[5]=32'h0; bz[5]=0; eb[5]=0; elc[5]=1;
        ls[6]=0; lv[6]=0; ll[6]=0; ld[6]=32'h0;         fe[6]=1; pv[6]=32'h4; bz[6]=0; eb[6]=0; elc[6]=1;
        for (int i = 0; i < 7; i++) begin
            load_start = ls[i];
            load_valid = lv[i];
            load_last  = ll[i];
            load_data  = ld[i];
            if (ls[i]) wp_m = 0;
            else if (bz[i] && lv[i]) begin
                model[wp_m] = ld[i];
                wp_m++;
            end
            drive_fetch(fe[i], 1'b0, 1'b0, pv[i], bz[i]);
            tick();
            e = sbq.pop_front();
            total_cnt++;
            if ({instr, instr_valid, misalign, addr_fault} !== e)
                $display("FAIL load_fetch[%0d]: got instr=%h vld=%b mis=%b flt=%b expected instr=%h vld=%b mis=%b flt=%b",
                         i, instr, instr_valid, misalign, addr_fault, e.instr, e.vld, e.mis, e.flt);
            else
                pass_cnt++;
            total_cnt++;
            if (busy !== eb[i]) $display("FAIL load_busy[%0d]: got %b expected %b", i, busy, eb[i]);
            else pass_cnt++;
            total_cnt++;
            if (load_count !== elc[i]) $display("FAIL load_cnt[%0d]: got %0d expected %0d", i, load_count, elc[i]);
            else pass_cnt++;
        end
        load_start = 0; load_valid = 0; load_last = 0;
        drive_fetch(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        void'(sbq.pop_front());
    endtask

    task automatic test_overflow();
        logic [31:0] pv [4];
        exp_t        e;
        exp_t        x;
        load_start8 = 1'b1;
        tick();
        load_start8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            load_valid8 = 1'b1;
            load_data8  = 32'hB000_0000 + 32'(i);
            if (i < 8) model8[i] = load_data8;
            tick();
            total_cnt++;
            if (busy8 !== (i < 7))
                $display("FAIL ovf_busy[%0d]: got %b expected %b", i, busy8, (i < 7));
            else
                pass_cnt++;
        end
        load_valid8 = 1'b0;
        total_cnt++;
        if (load_count8 !== 5'd8) $display("FAIL ovf_load_count: got %0d expected 8", load_count8);
        else pass_cnt++;
        pv[0] = 32'h0; pv[1] = 32'h4; pv[2] = 32'h1C; pv[3] = 32'h20;
        for (int i = 0; i < 4; i++) begin
            fetch_en8 = 1'b1;
            pc8       = pv[i];
            if (i < 3) x = '{instr: model8[pv[i][4:2]], vld: 1'b1, mis: 1'b0, flt: 1'b0};
            else       x = '{instr: NOP, vld: 1'b1, mis: 1'b0, flt: BC};
            sbq8.push_back(x);
            tick();
            e = sbq8.pop_front();
            total_cnt++;
            if ({instr8, instr_valid8, misalign8, addr_fault8} !== e)
                $display("FAIL ovf_fetch[%0d]: got instr=%h vld=%b mis=%b flt=%b expected instr=%h vld=%b mis=%b flt=%b",
                         i, instr8, instr_valid8, misalign8, addr_fault8, e.instr, e.vld, e.mis, e.flt);
            else
                pass_cnt++;
        end
        fetch_en8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_stall_flush();
        test_misalign_range();
        test_fetch_during_load();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
